// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: status codes, special register/instruction IDs,
// and the widths used by the writeback stage.
package y86_pkg;

    localparam int NREGS  = 15;
    localparam int CNT_W  = 64;
    localparam int DATA_W = 64;

    typedef enum logic [1:0] {
        STAT_AOK = 2'd0,
        STAT_HLT = 2'd1,
        STAT_ADR = 2'd2,
        STAT_INS = 2'd3
    } stat_e;

    localparam logic [3:0] RNONE  = 4'hF;
    localparam logic [3:0] I_HALT = 4'h0;
    localparam logic [3:0] I_NOP  = 4'h1;

endpackage

// File: rtl/y86_regfile.sv
// 15 x 64-bit Y86-64 register file: two write ports where M beats E on a
// shared destination, three asynchronous read ports that return 0 for RNONE.
module y86_regfile
    import y86_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [3:0]        dst_e,
    input  logic [DATA_W-1:0] val_e,
    input  logic [3:0]        dst_m,
    input  logic [DATA_W-1:0] val_m,
    input  logic [3:0]        src_a,
    input  logic [3:0]        src_b,
    input  logic [3:0]        src_dbg,
    output logic [DATA_W-1:0] rval_a,
    output logic [DATA_W-1:0] rval_b,
    output logic [DATA_W-1:0] rval_dbg
);

    logic [DATA_W-1:0] regs [NREGS];

    // NOTE: this storage is reset because the architecture defines every register as 0
    // after reset; that forces flops rather than a RAM macro, which is fine at 15 entries.
    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NREGS; i++) begin
                if (dst_m == 4'(i))      regs[i] <= val_m;
                else if (dst_e == 4'(i)) regs[i] <= val_e;
            end
        end
    end

    // Decoding the address against each entry means RNONE simply matches nothing.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rval_a   = '0;
        rval_b   = '0;
        rval_dbg = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (src_a   == 4'(i)) rval_a   = regs[i];
            if (src_b   == 4'(i)) rval_b   = regs[i];
            if (src_dbg == 4'(i)) rval_dbg = regs[i];
        end
    end

endmodule

// File: rtl/writeback_regfile.sv
// Y86-64 writeback stage: commits W results into the register file, latches
// the first non-AOK status and stops, and keeps cycle/retire counters.
module writeback_regfile
    import y86_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        W_stat,
    input  logic [3:0]        W_icode,
    input  logic [DATA_W-1:0] W_valE,
    input  logic [DATA_W-1:0] W_valM,
    input  logic [3:0]        W_dstE,
    input  logic [3:0]        W_dstM,
    input  logic [3:0]        d_srcA,
    input  logic [3:0]        d_srcB,
    output logic [DATA_W-1:0] d_rvalA,
    output logic [DATA_W-1:0] d_rvalB,
    input  logic [3:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [1:0]        cpu_stat,
    output logic              halted,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  retire_cnt
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [0:0] state;
    logic       running;
    logic       w_ok;
    logic       commit_en;

    assign running   = (state == ST_RUN);
    assign w_ok      = (W_stat == STAT_AOK);
    assign commit_en = running && w_ok;
    assign halted    = (state == ST_HALT);

    // The instruction that carries a bad status is neither written nor retired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            cpu_stat   <= STAT_AOK;
            cycle_cnt  <= '0;
            retire_cnt <= '0;
        end else if (running) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (w_ok) begin
                if (W_icode != I_NOP) retire_cnt <= retire_cnt + CNT_W'(1);
            end else begin
                state    <= ST_HALT;
                cpu_stat <= W_stat;
            end
        end
    end

    y86_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (commit_en),
        .dst_e    (W_dstE),
        .val_e    (W_valE),
        .dst_m    (W_dstM),
        .val_m    (W_valM),
        .src_a    (d_srcA),
        .src_b    (d_srcB),
        .src_dbg  (dbg_addr),
        .rval_a   (d_rvalA),
        .rval_b   (d_rvalB),
        .rval_dbg (dbg_data)
    );

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile: directed scenarios plus random
// traffic, all compared against an array-based architectural model.
module tb_writeback_regfile;
    import y86_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  W_stat = STAT_AOK;
    logic [3:0]  W_icode = I_NOP;
    logic [63:0] W_valE = '0;
    logic [63:0] W_valM = '0;
    logic [3:0]  W_dstE = RNONE;
    logic [3:0]  W_dstM = RNONE;
    logic [3:0]  d_srcA = RNONE;
    logic [3:0]  d_srcB = RNONE;
    logic [3:0]  dbg_addr = RNONE;
    logic [63:0] d_rvalA, d_rvalB, dbg_data, cycle_cnt, retire_cnt;
    logic [1:0]  cpu_stat;
    logic        halted;

    int n_checks = 0;
    int n_errors = 0;

    always #20 clk = ~clk;

    writeback_regfile dut (
        .clk(clk), .rst_n(rst_n),
        .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
        .W_dstE(W_dstE), .W_dstM(W_dstM),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .d_rvalA(d_rvalA), .d_rvalB(d_rvalB),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .cpu_stat(cpu_stat), .halted(halted),
        .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
    );

    // Architectural model: 16-slot array where slot F is never written.
    logic [63:0] m_regs [16];
    logic [1:0]  m_stat;
    logic        m_halted;
    logic [63:0] m_cycle, m_retire;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            m_stat = STAT_AOK; m_halted = 1'b0; m_cycle = '0; m_retire = '0;
        end else if (!m_halted) begin
            m_cycle = m_cycle + 1;
            if (W_stat == STAT_AOK) begin
                if (W_dstE != RNONE) m_regs[W_dstE] = W_valE;
                if (W_dstM != RNONE) m_regs[W_dstM] = W_valM;
                if (W_icode != I_NOP) m_retire = m_retire + 1;
            end else begin
                m_stat = W_stat;
                m_halted = 1'b1;
            end
        end
    end

    function automatic logic [63:0] m_read(input logic [3:0] a);
        return (a == RNONE) ? 64'd0 : m_regs[a];
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 1 unit after the rising edge, so they commit on the next one.
    task automatic apply(input logic [1:0] s, input logic [3:0] ic, input logic [63:0] ve,
                         input logic [63:0] vm, input logic [3:0] de, input logic [3:0] dm);
        @(posedge clk); #1;
        W_stat = s; W_icode = ic; W_valE = ve; W_valM = vm; W_dstE = de; W_dstM = dm;
    endtask

    task automatic idle();
        apply(STAT_AOK, I_NOP, 64'd0, 64'd0, RNONE, RNONE);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_stat"},   64'(cpu_stat), 64'(m_stat));
        check({tag, "_halted"}, 64'(halted),   64'(m_halted));
        check({tag, "_cycle"},  cycle_cnt,     m_cycle);
        check({tag, "_retire"}, retire_cnt,    m_retire);
    endtask

    task automatic sweep(input string tag);
        @(posedge clk); #2;
        for (int r = 0; r < 16; r++) begin
            dbg_addr = 4'(r); #1;
            check($sformatf("%s_r%0d", tag, r), dbg_data, m_read(4'(r)));
        end
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        W_stat = STAT_AOK; W_icode = I_NOP; W_dstE = RNONE; W_dstM = RNONE;
        rst_n = 1'b0; #2;
        rst_n = 1'b1;
    endtask

    logic [63:0] saved;

    initial begin
        #3 rst_n = 1'b0;
        #7 rst_n = 1'b1;

        // Reset state
        @(posedge clk); #2;
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_stat", 64'(cpu_stat), 64'(STAT_AOK));
        check("rst_retire", retire_cnt, 64'd0);
        sweep("rst");

        // 1: simple valE write to rax
        do_reset();
        apply(STAT_AOK, 4'h6, 64'h5, 64'h0, 4'd0, RNONE);
        idle(); #2;
        d_srcA = 4'd0; #1;
        check("t1_rvalA", d_rvalA, 64'h5);
        check("t1_retire", retire_cnt, 64'd1);
        check_state("t1");

        // 2: same destination on both ports, M wins
        apply(STAT_AOK, 4'h6, 64'h11, 64'h22, 4'd3, 4'd3);
        idle(); #2;
        d_srcB = 4'd3; #1;
        check("t2_rvalB", d_rvalB, 64'h22);

        // 3: writes to RNONE change nothing; RNONE reads as zero
        apply(STAT_AOK, 4'h6, 64'hFF, 64'hFF, RNONE, RNONE);
        idle(); #2;
        d_srcB = RNONE; #1;
        check("t3_rvalB", d_rvalB, 64'd0);
        sweep("t3");

        // 4: bubbles are not retired; HLT stops commit one edge later
        repeat (3) idle();
        apply(STAT_HLT, I_HALT, 64'd0, 64'd0, RNONE, RNONE); #2;
        check("t4_pre_halted", 64'(halted), 64'd0);
        apply(STAT_AOK, 4'h6, 64'h77, 64'h0, 4'd1, RNONE); #2;
        check("t4_halted", 64'(halted), 64'd1);
        check("t4_stat", 64'(cpu_stat), 64'(STAT_HLT));
        check("t4_retire", retire_cnt, 64'd3);
        saved = m_cycle;
        idle(); idle(); #2;
        dbg_addr = 4'd1; #1;
        check("t4_r1", dbg_data, 64'd0);
        check("t4_cycle_frozen", cycle_cnt, saved);
        check_state("t4");

        // 5: ADR status blocks its own load and freezes the cycle counter
        do_reset();
        apply(STAT_AOK, 4'h6, 64'h7, 64'h0, 4'd2, RNONE);
        apply(STAT_ADR, 4'h5, 64'h0, 64'h9, RNONE, 4'd2);
        idle(); #2;
        dbg_addr = 4'd2; #1;
        check("t5_r2", dbg_data, 64'h7);
        check("t5_stat", 64'(cpu_stat), 64'(STAT_ADR));
        saved = m_cycle;
        idle(); idle(); #2;
        check("t5_cycle_frozen", cycle_cnt, saved);

        // 6: asynchronous reset between clock edges
        do_reset();
        apply(STAT_AOK, 4'h6, 64'h5, 64'h0, 4'd0, RNONE);
        idle(); #2;
        dbg_addr = 4'd0; #1;
        check("t6_pre_r0", dbg_data, 64'h5);
        #5 rst_n = 1'b0; #1;
        check("t6_r0", dbg_data, 64'd0);
        check("t6_cycle", cycle_cnt, 64'd0);
        check("t6_retire", retire_cnt, 64'd0);
        check("t6_halted", 64'(halted), 64'd0);
        #3 rst_n = 1'b1;

        // Random traffic with occasional faulting status
        for (int n = 0; n < 400; n++) begin
            logic [1:0] s;
            logic [3:0] de, dm;
            if (m_halted) do_reset();
            s  = ($urandom_range(0, 40) == 0) ? 2'($urandom_range(1, 3)) : STAT_AOK;
            de = ($urandom_range(0, 3) == 0) ? RNONE : 4'($urandom_range(0, 14));
            dm = ($urandom_range(0, 2) == 0) ? RNONE : 4'($urandom_range(0, 14));
            apply(s, 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, de, dm);
            #2;
            d_srcA = ($urandom_range(0, 1) == 0) ? de : 4'($urandom);
            d_srcB = 4'($urandom); #1;
            check("rnd_rvalA", d_rvalA, m_read(d_srcA));
            check("rnd_rvalB", d_rvalB, m_read(d_srcB));
            check_state("rnd");
            if (n % 50 == 49) sweep("rnd_sweep");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
